// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD bus sequencer: state encoding,
// the power-up init command list and helpers that classify commands.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int INIT_LEN = 4;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNC_SET;
      2'd1:    return LCD_CMD_DISP_ON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction

  // Clear and home need the long post-write wait; everything else uses the short one.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-port grant logic for LCD byte writers. Round-robin by default; defining
// LCD_FIXED_PRIO_EN makes port 0 always win and drops the last-granted pointer.
module lcd_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       accept_en_i,
  input  logic       xfer_i,
  output logic [1:0] grant_o
);

`ifdef LCD_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = clk_i ^ rst_i ^ xfer_i;

  always_comb begin
    grant_o = 2'b00;
    if (accept_en_i) begin
      if (valid_i[0])      grant_o = 2'b01;
      else if (valid_i[1]) grant_o = 2'b10;
    end
  end
`else
  logic last_q;
  logic last_d;

  always_comb begin
    grant_o = 2'b00;
    last_d  = last_q;
    if (accept_en_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    if (xfer_i) last_d = grant_o[1];
  end

  // Pointer starts at port 1 so port 0 wins the first contest.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 bus owner: power-up wait, init command list, then arbitrated byte
// writes with setup/EN/hold/post-write timing. Option macro: LCD_FIXED_PRIO_EN.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_PULSE_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter int unsigned POWERUP_CYC    = 750000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       busy,
  output logic       init_done
);

  localparam int unsigned MAX_A   = (SETUP_CYC > EN_PULSE_CYC) ? SETUP_CYC : EN_PULSE_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > POWERUP_CYC) ? MAX_C : POWERUP_CYC;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             init_done_q, init_done_d;

  logic [1:0]       grant;
  logic             accept_en;
  logic             xfer;

  assign accept_en = (state_q == ST_IDLE) && init_done_q;
  assign xfer      = |(grant & {req1_valid, req0_valid});

  lcd_rr_arbiter u_arb (
    .clk_i       (CLOCK_50),
    .rst_i       (RST),
    .valid_i     ({req1_valid, req0_valid}),
    .accept_en_i (accept_en),
    .xfer_i      (xfer),
    .grant_o     (grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    en_d        = en_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_INIT: begin
        data_d  = init_cmd(idx_q);
        rs_d    = 1'b0;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
        state_d = ST_SETUP;
      end
      ST_IDLE: begin
        if (xfer) begin
          rs_d    = grant[1] ? req1_rs   : req0_rs;
          data_d  = grant[1] ? req1_data : req0_data;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          cnt_d   = CNT_W'(EN_PULSE_CYC - 1);
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = is_slow_cmd(rs_q, data_q) ? CNT_W'(CLEAR_WAIT_CYC - 1)
                                              : CNT_W'(CMD_WAIT_CYC - 1);
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == 2'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= CNT_W'(POWERUP_CYC - 1);
      idx_q       <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      init_done_q <= init_done_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = en_q;
  assign busy       = (state_q != ST_IDLE);
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with shortened timing parameters.
module tb_lcd_bus_sequencer;

  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int CMDW  = 5;
  localparam int CLRW  = 20;
  localparam int PWR   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, busy, init_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_cmd [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         exp_gap [3] = '{10, 10, 25};
  logic       wl_rs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] wl_data [4] = '{8'h01, 8'h01, 8'h02, 8'h03};
  int         wl_exp  [4] = '{27, 12, 27, 12};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_bus_sequencer #(
    .SETUP_CYC      (SETUP),
    .EN_PULSE_CYC   (PULSE),
    .CMD_WAIT_CYC   (CMDW),
    .CLEAR_WAIT_CYC (CLRW),
    .POWERUP_CYC    (PWR)
  ) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .LCD_DATA   (LCD_DATA),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_EN     (LCD_EN),
    .busy       (busy),
    .init_done  (init_done)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_en(input logic lvl, input int limit, output bit to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (LCD_EN === lvl) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic wait_busy(input logic lvl, input int limit, output bit to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (busy === lvl) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({LCD_EN, LCD_RS, LCD_RW, LCD_DATA} !== 11'h000) begin
      bad++;
      $display("FAIL reset_bus got en=%b rs=%b rw=%b data=%h exp all 0", LCD_EN, LCD_RS, LCD_RW, LCD_DATA);
    end
    total++;
    if ({busy, init_done, req0_ready, req1_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_status got busy=%b init_done=%b rdy0=%b rdy1=%b exp 1000",
               busy, init_done, req0_ready, req1_ready);
    end
    $display("reset: busy=%b init_done=%b en=%b", busy, init_done, LCD_EN);
  endtask

  task automatic test_init();
    int t_rel, t_rise, t_fall;
    bit to;
    rst   = 1'b0;
    t_rel = cyc;
    t_fall = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_en(1'b1, 60, to);
      total++;
      if (to) begin bad++; $display("FAIL init_rise_timeout k=%0d got no EN exp rise", k); end
      if (k == 0) begin
        total++;
        if (cyc - t_rel != 13) begin
          bad++; $display("FAIL init_first_rise got=%0d exp=13", cyc - t_rel);
        end
      end else begin
        total++;
        if (cyc - t_fall != exp_gap[k-1]) begin
          bad++; $display("FAIL init_gap k=%0d got=%0d exp=%0d", k, cyc - t_fall, exp_gap[k-1]);
        end
      end
      total++;
      if (LCD_DATA !== exp_cmd[k] || LCD_RS !== 1'b0 || init_done !== 1'b0) begin
        bad++;
        $display("FAIL init_cmd k=%0d got data=%h rs=%b init_done=%b exp data=%h rs=0 init_done=0",
                 k, LCD_DATA, LCD_RS, init_done, exp_cmd[k]);
      end
      t_rise = cyc;
      wait_en(1'b0, 10, to);
      total++;
      if (to || cyc - t_rise != PULSE) begin
        bad++; $display("FAIL init_width k=%0d got=%0d exp=%0d", k, cyc - t_rise, PULSE);
      end
      t_fall = cyc;
      $display("init: cmd %0d data=%h width=%0d", k, exp_cmd[k], cyc - t_rise);
    end
    wait_busy(1'b0, 50, to);
    total++;
    if (to || cyc - t_fall != 7) begin
      bad++; $display("FAIL init_to_idle got=%0d exp=7", cyc - t_fall);
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL init_done got=%b exp=1", init_done);
    end
  endtask

  task automatic test_single_write();
    int t_x, t_r;
    bit to;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h35;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready got rdy0=%b rdy1=%b exp 1 0", req0_ready, req1_ready);
    end
    step();
    t_x = cyc;
    total++;
    if (req0_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready_drop got=%b exp=0", req0_ready);
    end
    req0_valid = 1'b0;
    total++;
    if (LCD_DATA !== 8'h35 || LCD_RS !== 1'b1 || LCD_EN !== 1'b0) begin
      bad++; $display("FAIL single_setup got data=%h rs=%b en=%b exp 35 1 0", LCD_DATA, LCD_RS, LCD_EN);
    end
    wait_en(1'b1, 10, to);
    total++;
    if (to || cyc - t_x != SETUP || LCD_DATA !== 8'h35 || LCD_RS !== 1'b1) begin
      bad++; $display("FAIL single_rise got delay=%0d data=%h rs=%b exp 2 35 1", cyc - t_x, LCD_DATA, LCD_RS);
    end
    t_r = cyc;
    wait_en(1'b0, 10, to);
    total++;
    if (to || cyc - t_r != PULSE) begin
      bad++; $display("FAIL single_width got=%0d exp=%0d", cyc - t_r, PULSE);
    end
    wait_busy(1'b0, 40, to);
    total++;
    if (to || cyc - t_x != 12) begin
      bad++; $display("FAIL single_latency got=%0d exp=12", cyc - t_x);
    end
    $display("single: data=35 rs=1 latency=%0d", cyc - t_x);
  endtask

  task automatic test_wait_len();
    int t_x;
    bit to;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1; req1_rs = wl_rs[i]; req1_data = wl_data[i];
      #1;
      total++;
      if (req1_ready !== 1'b1) begin
        bad++; $display("FAIL wait_ready i=%0d got=%b exp=1", i, req1_ready);
      end
      step();
      t_x = cyc;
      req1_valid = 1'b0;
      total++;
      if (LCD_DATA !== wl_data[i] || LCD_RS !== wl_rs[i]) begin
        bad++; $display("FAIL wait_latch i=%0d got data=%h rs=%b exp data=%h rs=%b",
                        i, LCD_DATA, LCD_RS, wl_data[i], wl_rs[i]);
      end
      wait_busy(1'b0, 60, to);
      total++;
      if (to || cyc - t_x != wl_exp[i]) begin
        bad++; $display("FAIL wait_len i=%0d got=%0d exp=%0d", i, cyc - t_x, wl_exp[i]);
      end
      $display("wait: rs=%b data=%h busy_cycles=%0d", wl_rs[i], wl_data[i], cyc - t_x);
    end
  endtask

  task automatic test_round_robin();
    int  exp_port;
    bit  to;
    logic [7:0] exp_data;
    logic [1:0] exp_grant;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h31;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h41;
    #1;
    for (int r = 0; r < 4; r++) begin
      wait_busy(1'b0, 40, to);
      total++;
      if (to) begin bad++; $display("FAIL rr_timeout r=%0d got busy=1 exp idle", r); end
`ifdef LCD_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = r % 2;
`endif
      exp_grant = (exp_port == 1) ? 2'b10 : 2'b01;
      exp_data  = (exp_port == 1) ? 8'h41 : 8'h31;
      total++;
      if ({req1_ready, req0_ready} !== exp_grant) begin
        bad++; $display("FAIL rr_grant r=%0d got=%b exp=%b", r, {req1_ready, req0_ready}, exp_grant);
      end
      step();
      total++;
      if (LCD_DATA !== exp_data) begin
        bad++; $display("FAIL rr_data r=%0d got=%h exp=%h", r, LCD_DATA, exp_data);
      end
      $display("rr: round %0d granted port %0d data=%h", r, exp_port, LCD_DATA);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_busy(1'b0, 40, to);
  endtask

  task automatic test_reset_mid();
    int  t_rel, t_first, rdy_seen;
    bit  to;
    logic [7:0] first_data;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    #1;
    step();
    req0_valid = 1'b0;
    wait_en(1'b1, 10, to);
    rst = 1'b1;
    #1;
    total++;
    if (to || {LCD_EN, LCD_RS, LCD_DATA, busy, init_done} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got en=%b rs=%b data=%h busy=%b init_done=%b exp 0 0 00 1 0",
               LCD_EN, LCD_RS, LCD_DATA, busy, init_done);
    end
    step();
    step();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h77;
    rst = 1'b0;
    t_rel = cyc;
    t_first = -1;
    first_data = 8'h00;
    rdy_seen = 0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (init_done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (req0_ready !== 1'b0) rdy_seen++;
      if (LCD_EN === 1'b1 && t_first < 0) begin
        t_first = cyc - t_rel;
        first_data = LCD_DATA;
      end
      step();
    end
    total++;
    if (to) begin bad++; $display("FAIL reinit_timeout got init_done=0 exp 1"); end
    total++;
    if (t_first != 13 || first_data !== 8'h38) begin
      bad++; $display("FAIL reinit_first got t=%0d data=%h exp t=13 data=38", t_first, first_data);
    end
    total++;
    if (rdy_seen != 0) begin
      bad++; $display("FAIL reinit_ready got=%0d ready cycles exp=0", rdy_seen);
    end
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL reinit_grant got=%b exp=1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    total++;
    if (LCD_DATA !== 8'h77 || LCD_RS !== 1'b1) begin
      bad++; $display("FAIL reinit_data got data=%h rs=%b exp 77 1", LCD_DATA, LCD_RS);
    end
    wait_busy(1'b0, 40, to);
    $display("reset_mid: reinit first cmd at %0d, held request data=%h", t_first, LCD_DATA);
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_wait_len();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Owns the 16x2 HD44780 LCD bus and sequences every write to it.
- After reset, runs the power-up wait and a fixed init command list.
- Then arbitrates between two byte-write requesters: port 0 carries score digits, port 1 carries status text.
- Generates the RS/DATA setup, EN pulse, hold and post-write wait timing. Sits between the game logic and the LCD pins.

Parameters:
- SETUP_CYC, 4: cycles RS/DATA are stable before EN rises; also the hold cycles after EN falls.
- EN_PULSE_CYC, 25: EN high width in cycles (500 ns at 50 MHz).
- CMD_WAIT_CYC, 2000: post-write wait for normal commands and data (40 us).
- CLEAR_WAIT_CYC, 82000: post-write wait after clear (0x01) or home (0x02) commands (1.64 ms).
- POWERUP_CYC, 750000: wait after reset before the first init command (15 ms).

Ports:
- CLOCK_50, in, 1: 50 MHz clock.
- RST, in, 1: asynchronous, active-high reset.
- req0_valid, in, 1: port 0 has a byte to write.
- req0_rs, in, 1: port 0 register select (0 = command, 1 = data).
- req0_data, in, 8: port 0 byte.
- req0_ready, out, 1: port 0 byte accepted this cycle.
- req1_valid, in, 1: port 1 has a byte to write.
- req1_rs, in, 1: port 1 register select.
- req1_data, in, 8: port 1 byte.
- req1_ready, out, 1: port 1 byte accepted this cycle.
- LCD_DATA, out, 8: LCD data bus (write-only).
- LCD_RS, out, 1: LCD register select.
- LCD_RW, out, 1: tied to 0.
- LCD_EN, out, 1: LCD enable strobe.
- busy, out, 1: high whenever state is not IDLE.
- init_done, out, 1: high once the init list has completed.

Behaviour:
- Reset values: LCD_DATA=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, reqN_ready=0, busy=1, init_done=0. The state machine goes to PWRUP.
- States: PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT.
- PWRUP: counts POWERUP_CYC cycles, then goes to INIT with init index 0.
- INIT: loads init command[idx] with RS=0, then goes to SETUP.
  - Init list, in order: 0x38, 0x0C, 0x01, 0x06.
  - Each init command uses the same SETUP/PULSE/HOLD/WAIT path as a requested write.
  - After the WAIT for idx 3 completes, init_done is set and stays high until reset; the machine goes to IDLE.
- IDLE: busy=0. The arbiter picks a winner among valid ports.
  - The winner's ready is asserted combinationally in that same cycle. Transfer happens when valid & ready are both high.
  - rs and data are latched into the output registers, and the machine goes to SETUP on the next edge.
  - ready is never asserted outside IDLE or before init_done.
  - Requesters hold valid/rs/data stable until they see ready.
- Arbitration: round-robin.
  - The last-granted pointer resets to 1, so port 0 wins the first contest.
  - When both ports are valid, the port not granted last wins.
  - When only one port is valid, it wins regardless of the pointer.
  - The pointer updates only on a transfer.
- SETUP: SETUP_CYC cycles with EN=0 and RS/DATA driven.
- PULSE: EN_PULSE_CYC cycles with EN=1.
- HOLD: SETUP_CYC cycles with EN=0; RS/DATA remain unchanged.
- WAIT: counts CLEAR_WAIT_CYC if the latched RS=0 and the latched data is 0x01 or 0x02; otherwise counts CMD_WAIT_CYC. Then returns to INIT (during init) or IDLE.
- Bus outputs are registered and hold their last value in IDLE.
- Latency: one accepted byte occupies 2*SETUP_CYC + EN_PULSE_CYC + wait cycles, then the machine is back in IDLE.
- Counters are sized to hold the largest parameter. Each load is value-1, and a state ends when its counter reaches 0.
- A RST assertion mid-write drops EN to 0 immediately, discards the latched byte, and restarts from PWRUP, which redoes the full init.

Optional Feature:
- Macro: LCD_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid; the round-robin pointer is removed.
- Undefined: round-robin arbitration as described in Behaviour.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - the init command constants and INIT_LEN=4;
  - LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02.
- One sub-module, lcd_rr_arbiter:
  - inputs: two valid bits, an accept enable and the transfer strobe;
  - outputs: the one-hot grant;
  - owns the last-granted pointer, and contains the LCD_FIXED_PRIO_EN switch.

Test Plan (bench parameters SETUP_CYC=2, EN_PULSE_CYC=3, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=20, POWERUP_CYC=10):
- Reset release, no requests -> EN stays 0 for 10 cycles. Then exactly four EN pulses, each 3 cycles wide, with RS=0 and DATA 0x38, 0x0C, 0x01, 0x06. The gap after 0x01 is 20 wait cycles plus 2 hold cycles. init_done rises and busy falls.
- After init, req0 writes rs=1 data=0x35 -> req0_ready high for 1 cycle. DATA=0x35 and RS=1 for 2 cycles before EN rises. EN high for 3 cycles. busy returns low 2+3+2+5=12 cycles after the transfer.
- Both ports valid continuously with distinct bytes (req0 0x31, req1 0x41) -> grants alternate 0,1,0,1. With LCD_FIXED_PRIO_EN defined, only port 0 is granted while it stays valid.
- req1 writes rs=0 data=0x01 -> post-write wait is 20 cycles. Repeating with rs=1 data=0x01 -> wait is 5 cycles.
- RST asserted during PULSE -> EN=0 and outputs at reset values in the same cycle, without waiting for a clock edge. After release, the full power-up and init sequence repeats. A request made during init gets no ready until init_done.
